snake_game_ctrl: RTL and testbench

Game-flow controller sitting directly upstream of the snake/food manager. Turns debounced button levels into a turn-safe direction, generates the periodic move strobe (`mv`), and the food-generation strobe (`genf`). Consumes the manager's `eat`/`col`/`len` to track score, speed and game-over, and holds the manager in reset outside a game.

---
 rtl/snake_game_ctrl.sv | 103 ++++++++++
 tb/tb_snake_game_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game-flow controller producing move/food strobes, direction, score and state; optional pause via SNAKE_PAUSE_EN
module snake_game_ctrl #(
    parameter int TICK_W   = 26,
    parameter int BASE_DIV = 25000000,
    parameter int MIN_DIV  = 4000000,
    parameter int STEP_DIV = 1000000,
    parameter int S_LEN_W  = 6,
    parameter int SCORE_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_start,
    input  logic               eat,
    input  logic               col,
    input  logic [S_LEN_W-1:0] len,
    output logic               core_rst,
    output logic               mv,
    output logic [1:0]         dir,
    output logic               genf,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score
);
    localparam int PW = TICK_W + S_LEN_W;

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, OVER = 2'd3} st_t;

    st_t               st;
    logic [4:0]        btn, prev, edg;
    logic [1:0]        pend, cand;
    logic [TICK_W-1:0] tick;
    logic [PW-1:0]     len_eff, red, period;
    logic              wrap, accept;

    assign state = st;
    assign btn   = {btn_start, btn_up, btn_down, btn_left, btn_right};
    assign edg   = btn & ~prev;

    // move period from snake length, clamped to MIN_DIV including subtraction underflow
    always_comb begin
        len_eff = (len < S_LEN_W'(3)) ? PW'(3) : PW'(len);
        red     = PW'(STEP_DIV) * (len_eff - PW'(3));
        period  = (red >= PW'(BASE_DIV) || PW'(BASE_DIV) - red < PW'(MIN_DIV)) ? PW'(MIN_DIV) : PW'(BASE_DIV) - red;
        wrap    = PW'(tick) >= period - PW'(1);
        cand    = edg[3] ? 2'b00 : edg[2] ? 2'b01 : edg[1] ? 2'b10 : 2'b11;
        accept  = (|edg[3:0]) && ((cand ^ dir) != 2'b01);
    end

    // game FSM with registered strobes, direction, score and tick counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= IDLE;
            core_rst <= 1'b1;
            mv       <= 1'b0;
            dir      <= 2'b11;
            pend     <= 2'b11;
            genf     <= 1'b0;
            score    <= '0;
            tick     <= '0;
            prev     <= '0;
        end else begin
            prev <= btn;
            mv   <= 1'b0;
            genf <= 1'b0;
            case (st)
                IDLE: if (edg[4]) begin
                    st       <= PLAY;
                    core_rst <= 1'b0;
                    score    <= '0;
                    dir      <= 2'b11;
                    pend     <= 2'b11;
                    tick     <= '0;
                end
                PLAY: if (col) begin
                    st <= OVER;
                end else begin
                    tick <= wrap ? '0 : tick + 1'b1;
                    mv   <= wrap;
                    if (wrap) dir <= pend;
                    if (accept) pend <= cand;
                    if (eat) begin
                        genf <= 1'b1;
                        if (score != '1) score <= score + 1'b1;
                    end
`ifdef SNAKE_PAUSE_EN
                    if (edg[4]) st <= PAUSE;
`endif
                end
`ifdef SNAKE_PAUSE_EN
                PAUSE: if (edg[4]) st <= PLAY;
`endif
                OVER: if (edg[4]) begin
                    st       <= IDLE;
                    core_rst <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed self-checking bench for snake_game_ctrl
module tb_snake_game_ctrl;
    localparam logic [4:0] B_ST = 5'b10000, B_UP = 5'b01000, B_DN = 5'b00100, B_LF = 5'b00010, B_RT = 5'b00001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_start = 0;
    logic       eat = 0, col = 0;
    logic [5:0] len = 6'd3;
    logic       core_rst, mv, genf;
    logic [1:0] dir, state;
    logic [7:0] score;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [5:0] l;
        int         sp;
    } pv_t;
    pv_t tbl[9];

    snake_game_ctrl #(
        .TICK_W(8), .BASE_DIV(20), .MIN_DIV(8), .STEP_DIV(4), .S_LEN_W(6), .SCORE_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
        .eat(eat), .col(col), .len(len),
        .core_rst(core_rst), .mv(mv), .dir(dir), .genf(genf), .state(state), .score(score)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic press(input logic [4:0] m);
        {btn_start, btn_up, btn_down, btn_left, btn_right} = m;
        step();
        {btn_start, btn_up, btn_down, btn_left, btn_right} = 5'b0;
        step();
    endtask

    task automatic wait_mv(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!mv && n < 200);
        if (!mv) n = -1;
    endtask

    task automatic quiet(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            hits += int'(mv) + int'(genf);
        end
    endtask

    initial begin
        int n;
        int h;
        tbl[0] = '{6'd3, 20};
        tbl[1] = '{6'd4, 16};
        tbl[2] = '{6'd5, 12};
        tbl[3] = '{6'd6, 8};
        tbl[4] = '{6'd7, 8};
        tbl[5] = '{6'd10, 8};
        tbl[6] = '{6'd0, 20};
        tbl[7] = '{6'd1, 20};
        tbl[8] = '{6'd63, 8};

        #2 rst = 1'b0;
        step();
        check("rst_state", state, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_mv", mv, 0);
        check("rst_dir", dir, 3);
        check("rst_score", score, 0);
        check("rst_genf", genf, 0);
        rst = 1'b1;
        step();
        step();
        check("idle_no_start", state, 0);

        press(B_ST);
        check("start_state", state, 1);
        check("start_core_rst", core_rst, 0);
        wait_mv(n);
        check("first_mv_delay", n, 19);
        wait_mv(n);
        check("mv_spacing_len3", n, 20);
        check("dir_initial", dir, 3);

        press(B_LF);
        press(B_UP);
        check("dir_before_mv", dir, 3);
        wait_mv(n);
        check("dir_up_committed", dir, 0);
        press(B_LF);
        press(B_RT);
        wait_mv(n);
        check("dir_overwrite_right", dir, 3);
        press(B_LF | B_DN);
        wait_mv(n);
        check("dir_priority_down", dir, 1);
        press(B_UP);
        wait_mv(n);
        check("dir_opposite_reject", dir, 1);

        step();
        eat = 1'b1;
        step();
        eat = 1'b0;
        check("eat_genf", genf, 1);
        check("eat_score", score, 1);
        step();
        check("genf_one_cycle", genf, 0);

        wait_mv(n);
        repeat (15) step();
        len = 6'd10;
        wait_mv(n);
        check("shrink_wrap_next", n, 1);

        for (int i = 0; i < 9; i++) begin
            len = tbl[i].l;
            wait_mv(n);
            check("period_sync", int'(n > 0), 1);
            wait_mv(n);
            check($sformatf("period_len%0d", tbl[i].l), n, tbl[i].sp);
        end
        len = 6'd3;

        eat = 1'b1;
        repeat (300) step();
        eat = 1'b0;
        step();
        check("score_saturate", score, 255);

        eat = 1'b1;
        col = 1'b1;
        step();
        eat = 1'b0;
        col = 1'b0;
        check("col_state", state, 3);
        check("col_score_kept", score, 255);
        check("col_no_genf", genf, 0);
        check("over_core_rst", core_rst, 0);
        quiet(100, h);
        check("over_quiet", h, 0);
        eat = 1'b1;
        step();
        eat = 1'b0;
        check("over_eat_ignored", score, 255);
        press(B_ST);
        check("over_to_idle", state, 0);
        check("idle_core_rst", core_rst, 1);
        eat = 1'b1;
        step();
        eat = 1'b0;
        check("idle_eat_genf", genf, 0);
        check("idle_eat_score", score, 255);

        press(B_ST);
        check("restart_state", state, 1);
        check("restart_score", score, 0);
        wait_mv(n);
        check("restart_first_mv", n, 19);
        repeat (5) step();
        press(B_ST);
`ifdef SNAKE_PAUSE_EN
        check("pause_state", state, 2);
        quiet(50, h);
        check("pause_quiet", h, 0);
        check("pause_hold", state, 2);
        press(B_ST);
        check("resume_state", state, 1);
        wait_mv(n);
        check("resume_remaining", n, 13);
`else
        check("no_pause_state", state, 1);
        quiet(50, h);
        check("no_pause_mv_count", h, 2);
        check("no_pause_hold", state, 1);
`endif

        press(B_UP);
        wait_mv(n);
        check("pre_rst_dir", dir, 0);
        step();
        eat = 1'b1;
        step();
        eat = 1'b0;
        check("pre_rst_score", score, 1);
        wait_mv(n);
        check("pre_rst_mv", mv, 1);
        rst = 1'b0;
        #1;
        check("async_state", state, 0);
        check("async_dir", dir, 3);
        check("async_score", score, 0);
        check("async_mv", mv, 0);
        check("async_core_rst", core_rst, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
